// File: rtl/mnist_frame_capture.sv
// 28x28 frame assembler with ping-pong buffer feeding the MNIST classifier.
// Optional: define FRAME_CAPTURE_BINARIZE_EN to store thresholded pixels.
module mnist_frame_capture #(
  parameter int PIX_W   = 8,
  parameter int IMG_DIM = 28,
  parameter int THRESH  = 128
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iStart_pixel,
  input  logic             iStart_stream,
  input  logic [PIX_W-1:0] iPixel,
  input  logic             iCapture_en,
  input  logic [9:0]       iRd_addr,
  output logic [PIX_W-1:0] oRd_data,
  output logic             oFrame_valid,
  input  logic             iFrame_done,
  output logic             oShort,
  output logic             oOverrun,
  output logic [7:0]       oFrame_cnt
);

  localparam int N = IMG_DIM * IMG_DIM;

`ifdef FRAME_CAPTURE_BINARIZE_EN
  localparam bit BIN_EN = 1'b1;
`else
  localparam bit BIN_EN = 1'b0;
`endif

  typedef enum logic {WAIT_SOF, CAPTURE} state_t;

  state_t           state_q, state_d;
  logic [9:0]       wr_cnt_q, wr_cnt_d;
  logic             wbank_q, wbank_d;
  logic             valid_q, valid_d;
  logic             short_q, short_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             we, last, swap;
  logic [PIX_W-1:0] bin, pix_w, rd_d, rd_q;

  logic [PIX_W-1:0] mem0 [N];
  logic [PIX_W-1:0] mem1 [N];

  assign bin   = (iPixel >= PIX_W'(THRESH)) ? {PIX_W{1'b1}} : '0;
  assign pix_w = BIN_EN ? bin : iPixel;

  // SOF wins over a coincident strobe, so the last write needs !iStart_pixel
  assign last = (state_q == CAPTURE) && iStart_stream &&
                !iStart_pixel && (wr_cnt_q == 10'(N - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= WAIT_SOF;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SOF: begin
        if (iStart_pixel && iCapture_en) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (iStart_pixel)
          state_d = iCapture_en ? CAPTURE : WAIT_SOF;
        else if (last)
          state_d = WAIT_SOF;
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_comb begin
    we       = 1'b0;
    short_d  = 1'b0;
    wr_cnt_d = wr_cnt_q;
    unique case (state_q)
      WAIT_SOF: begin
        if (iStart_pixel) wr_cnt_d = '0;
      end
      CAPTURE: begin
        if (iStart_pixel) begin
          short_d  = 1'b1;
          wr_cnt_d = '0;
        end else if (iStart_stream) begin
          we       = 1'b1;
          wr_cnt_d = last ? '0 : wr_cnt_q + 10'd1;
        end
      end
      default: wr_cnt_d = '0;
    endcase
  end

  // A release in the commit cycle frees the read bank for the swap
  assign swap = last && (!valid_q || iFrame_done);

  always_comb begin
    valid_d = valid_q;
    if (iFrame_done) valid_d = 1'b0;
    if (swap)        valid_d = 1'b1;
    wbank_d = swap ? ~wbank_q : wbank_q;
    cnt_d   = swap ? cnt_q + 8'd1 : cnt_q;
    ovr_d   = last && !swap;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_cnt_q <= '0;
      wbank_q  <= 1'b0;
      valid_q  <= 1'b0;
      short_q  <= 1'b0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      wbank_q  <= wbank_d;
      valid_q  <= valid_d;
      short_q  <= short_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (we) begin
      if (wbank_q) mem1[wr_cnt_q] <= pix_w;
      else         mem0[wr_cnt_q] <= pix_w;
    end
  end

  // Read bank is always the one not being written
  always_comb begin
    rd_d = '0;
    if (iRd_addr < 10'(N))
      rd_d = wbank_q ? mem0[iRd_addr] : mem1[iRd_addr];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) rd_q <= '0;
    else         rd_q <= rd_d;
  end

  assign oRd_data     = rd_q;
  assign oFrame_valid = valid_q;
  assign oShort       = short_q;
  assign oOverrun     = ovr_q;
  assign oFrame_cnt   = cnt_q;

endmodule

// File: tb/tb_mnist_frame_capture.sv
// Bench for mnist_frame_capture: directed frames, read-vector table and
// randomized traffic against a frame-level queue/array reference model.
module tb_mnist_frame_capture;

  localparam int N = 784;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sof = 1'b0, strb = 1'b0, en = 1'b0, done = 1'b0;
  logic [7:0] pix = '0;
  logic [9:0] ra = '0;
  logic [7:0] rd;
  logic       valid, shrt, ovr;
  logic [7:0] cnt;

  mnist_frame_capture dut (
    .iCLK          (clk),
    .iRST_N        (rst_n),
    .iStart_pixel  (sof),
    .iStart_stream (strb),
    .iPixel        (pix),
    .iCapture_en   (en),
    .iRd_addr      (ra),
    .oRd_data      (rd),
    .oFrame_valid  (valid),
    .iFrame_done   (done),
    .oShort        (shrt),
    .oOverrun      (ovr),
    .oFrame_cnt    (cnt)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  bit         m_cap, m_valid, m_have, m_short, m_ovr;
  int         m_cnt;
  logic [7:0] m_cur[$];
  logic [7:0] m_img[N];

  typedef struct {
    logic [9:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[8];

  function automatic logic [7:0] store(input logic [7:0] p);
`ifdef FRAME_CAPTURE_BINARIZE_EN
    return (p >= 8'd128) ? 8'hFF : 8'h00;
`else
    return p;
`endif
  endfunction

  function automatic logic [9:0] rda();
    return 10'($urandom_range(0, 1023));
  endfunction

  function automatic logic [7:0] pixv(input int i, input int pm);
    logic [7:0] v;
    v = 8'(i);
    if (pm == 1) v = 8'($urandom);
    if (pm == 2 && i == 0) v = 8'd127;
    if (pm == 2 && i == 1) v = 8'd128;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_valid = 0; m_have = 0;
    m_short = 0; m_ovr = 0; m_cnt = 0;
    m_cur.delete();
  endtask

  task automatic model_step(input bit s, input bit st, input logic [7:0] p,
                            input bit e, input bit d);
    bit commit, old_valid;
    commit = 0;
    old_valid = m_valid;
    m_short = 0;
    m_ovr = 0;
    if (!m_cap) begin
      if (s && e) begin
        m_cap = 1;
        m_cur.delete();
      end
    end else if (s) begin
      m_short = 1;
      m_cur.delete();
      m_cap = e;
    end else if (st) begin
      m_cur.push_back(store(p));
      if (m_cur.size() == N) begin
        commit = 1;
        m_cap = 0;
      end
    end
    if (d) m_valid = 0;
    if (commit) begin
      if (!old_valid || d) begin
        for (int i = 0; i < N; i++) m_img[i] = m_cur[i];
        m_valid = 1;
        m_have = 1;
        m_cnt = (m_cnt + 1) % 256;
      end else begin
        m_ovr = 1;
      end
      m_cur.delete();
    end
  endtask

  task automatic step(input bit s, input bit st, input logic [7:0] p,
                      input bit e, input bit d, input logic [9:0] a);
    logic [7:0] erd;
    bit known;
    sof = s; strb = st; pix = p; en = e; done = d; ra = a;
    known = (a >= 10'(N)) || m_have;
    erd = 8'h00;
    if (a < 10'(N)) erd = m_img[a];
    @(posedge clk);
    model_step(s, st, p, e, d);
    #1;
    chk("valid", valid, m_valid);
    chk("short", shrt, m_short);
    chk("overrun", ovr, m_ovr);
    chk("frame_cnt", cnt, m_cnt);
    if (known) chk("rd_data", rd, erd);
  endtask

  task automatic rst_check(input string nm);
    chk({nm, "_rd"}, rd, 0);
    chk({nm, "_valid"}, valid, 0);
    chk({nm, "_short"}, shrt, 0);
    chk({nm, "_overrun"}, ovr, 0);
    chk({nm, "_cnt"}, cnt, 0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    sof = 0; strb = 0; done = 0; en = 0;
    #1;
    rst_check("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int ns, input int gap, input int pm,
                         input bit dl, input int rst_at, input bit e);
    for (int i = 0; i < ns; i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      repeat ($urandom_range(0, gap)) step(0, 0, 8'($urandom), e, 0, rda());
      step(0, 1, pixv(i, pm), e, dl && (i == ns - 1), rda());
    end
  endtask

  initial begin
    bit s;
    int dv;
    tbl[0] = '{10'd300,  8'd44};
    tbl[1] = '{10'd0,    8'd0};
    tbl[2] = '{10'd1,    8'd1};
    tbl[3] = '{10'd511,  8'd255};
    tbl[4] = '{10'd512,  8'd0};
    tbl[5] = '{10'd783,  8'd15};
    tbl[6] = '{10'd784,  8'd0};
    tbl[7] = '{10'd1023, 8'd0};

    model_reset();
    #12;
    rst_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(1, 0, 0, 1, 0, rda());
    strobes(N, 0, 0, 0, -1, 1);
    chk("first_commit_valid", valid, 1);
    chk("first_commit_cnt", cnt, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0, tbl[i].addr);
      chk("tbl_rd", rd, store(tbl[i].exp));
    end

    step(0, 0, 0, 1, 1, rda());
    step(1, 0, 0, 1, 0, rda());
    strobes(500, 2, 1, 0, -1, 1);
    step(1, 0, 0, 1, 0, rda());
    chk("short_pulse", shrt, 1);
    chk("short_no_valid", valid, 0);
    strobes(N, 0, 0, 0, -1, 1);
    chk("after_short_valid", valid, 1);
    chk("after_short_cnt", cnt, 2);

    step(0, 0, 0, 1, 1, rda());
    step(1, 0, 0, 1, 0, rda());
    strobes(N, 2, 2, 0, -1, 1);
    step(0, 0, 0, 1, 0, 10'd0);
    chk("thresh_127", rd, store(8'd127));
    step(0, 0, 0, 1, 0, 10'd1);
    chk("thresh_128", rd, store(8'd128));
    chk("thresh_cnt", cnt, 3);

    step(1, 0, 0, 1, 0, rda());
    strobes(N, 1, 1, 0, -1, 1);
    chk("overrun_pulse", ovr, 1);
    chk("overrun_cnt", cnt, 3);
    step(0, 0, 0, 1, 0, 10'd0);
    chk("overrun_keeps_rd", rd, store(8'd127));
    step(0, 0, 0, 1, 1, rda());
    step(1, 0, 0, 1, 0, rda());
    strobes(N, 0, 1, 0, -1, 1);
    chk("frame3_cnt", cnt, 4);

    step(1, 0, 0, 1, 0, rda());
    strobes(N, 0, 1, 1, -1, 1);
    chk("done_commit_valid", valid, 1);
    chk("done_commit_cnt", cnt, 5);
    repeat (8) step(0, 0, 0, 1, 0, 10'($urandom_range(0, N - 1)));

    step(0, 0, 0, 1, 1, rda());
    step(1, 0, 0, 0, 0, rda());
    strobes(N, 0, 1, 0, -1, 0);
    chk("disarmed_valid", valid, 0);
    chk("disarmed_cnt", cnt, 5);

    step(1, 0, 0, 1, 0, rda());
    strobes(N, 0, 0, 0, 400, 1);
    step(1, 0, 0, 1, 0, rda());
    strobes(N, 0, 0, 0, -1, 1);
    chk("post_reset_valid", valid, 1);
    chk("post_reset_cnt", cnt, 1);
    step(0, 0, 0, 1, 0, 10'd300);
    chk("post_reset_rd300", rd, store(8'd44));

    dv = 1;
    for (int c = 0; c < 24000; c++) begin
      if (c % 3000 == 0) dv = 1 << $urandom_range(0, 2);
      s = m_cap ? ($urandom_range(0, 2999) == 0) : ($urandom_range(0, 19) == 0);
      step(s, $urandom_range(0, dv - 1) == 0, 8'($urandom),
           $urandom_range(0, 9) != 0, $urandom_range(0, 299) == 0, rda());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mnist_frame_capture.md
# mnist_frame_capture

Downstream of the VGA/camera sampling controller: consumes its per-pixel sample strobe and the 8-bit BW/grey pixel, and assembles one 28x28 (784-pixel) image per video frame. Each completed image is stored in a ping-pong buffer and presented to the MNIST classifier through a valid/done handshake and a synchronous read port. Capture continues into the alternate bank while the classifier reads the committed one.

## Interface
- PIX_W, 8, pixel width stored per sample
- IMG_DIM, 28, image side; frame size N = IMG_DIM*IMG_DIM (784)
- THRESH, 128, binarization threshold (used only when macro enabled)
- iCLK  in  1  pixel clock
- iRST_N  in  1  reset; asynchronous, active-low
- iStart_pixel  in  1  start-of-frame pulse from sampling controller
- iStart_stream  in  1  sample strobe; one per downsampled pixel, raster order
- iPixel  in  PIX_W  pixel value, valid when iStart_stream=1
- iCapture_en  in  1  arm capture; sampled at iStart_pixel
- iRd_addr  in  10  classifier read address, 0..N-1
- oRd_data  out  PIX_W  read data, 1-cycle latency
- oFrame_valid  out  1  committed image available in read bank
- iFrame_done  in  1  classifier finished with read bank (1-cycle pulse)
- oShort  out  1  1-cycle pulse: frame ended with fewer than N samples
- oOverrun  out  1  1-cycle pulse: completed frame dropped, read bank busy
- oFrame_cnt  out  8  committed-frame counter, wraps 255->0

## Operation
- Reset: state WAIT_SOF, wr_cnt=0, wbank=0, rbank=1, oFrame_valid=0, oShort=0, oOverrun=0, oFrame_cnt=0, oRd_data=0.
- WAIT_SOF: strobes ignored. iStart_pixel & iCapture_en -> CAPTURE, wr_cnt=0.
- CAPTURE: each iStart_stream writes pixel into bank wbank at address wr_cnt, wr_cnt++.
- Strobe with wr_cnt==N-1: write, then commit; wr_cnt=0 -> WAIT_SOF.
- Commit: if oFrame_valid=0 (or iFrame_done in same cycle): swap wbank/rbank, oFrame_valid=1, oFrame_cnt++. Otherwise oOverrun pulse, no swap; write bank is overwritten by next frame.
- iStart_pixel in CAPTURE with wr_cnt<N: oShort pulse, partial data discarded, wr_cnt=0; stay CAPTURE if iCapture_en=1, else WAIT_SOF. iStart_pixel and a strobe in the same cycle: strobe is dropped and treated as the new frame boundary.
- Strobes beyond N before next iStart_pixel cannot occur (returns to WAIT_SOF after N).
- iFrame_done with oFrame_valid=1: oFrame_valid=0 next cycle. iFrame_done with oFrame_valid=0: ignored.
- Read: oRd_data = bank[rbank][iRd_addr] registered; iRd_addr>=N returns 0. Read bank never written while oFrame_valid=1.
- iCapture_en deassert mid-CAPTURE does not abort the current frame.

## Timing
- Strobes accepted every cycle (back-to-back); nominal rate 1 per 16 clocks.
- Commit: oFrame_valid rises the cycle after the N-th strobe.
- oShort/oOverrun: asserted the cycle after the causing event, exactly one cycle.
- oRd_data: valid one cycle after iRd_addr presented.
- Reset mid-operation: all state to reset values immediately (async); buffer contents undefined, oFrame_valid=0.
- wr_cnt 10 bits; addressing linear = row*IMG_DIM + col from strobe order.

## Configuration
- FRAME_CAPTURE_BINARIZE_EN defined: stored pixel = (iPixel >= THRESH) ? all-ones : 0.
- Undefined: iPixel stored unmodified; THRESH unused.

## Test plan
- Reset then 784 strobes with iPixel=addr[7:0] after SOF -> oFrame_valid=1 one cycle after last strobe, read addr 300 returns 44 (raw build), oFrame_cnt=1.
- Binarize build: iPixel=127 at addr 0, 128 at addr 1 -> reads 0x00, 0xFF.
- SOF after 500 strobes -> oShort pulse, oFrame_valid stays 0; following full frame commits normally.
- Frame 1 committed, no iFrame_done, frame 2 completes -> oOverrun pulse, read data still frame 1; assert iFrame_done, frame 3 commits into valid bank.
- iFrame_done in same cycle as commit -> oFrame_valid stays 1, read port shows new frame, oFrame_cnt increments.
- iCapture_en=0 at SOF -> strobes ignored, no valid; async reset mid-CAPTURE at strobe 400 -> all outputs zero, next armed frame commits after 784 strobes.
